// File: rtl/src_switch_pkg.sv
// Shared types and constant helpers for the click-free sample source switch.
package src_switch_pkg;

    typedef enum logic {
        PASS = 1'b0,
        MUTE = 1'b1
    } state_t;

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Mute code: midscale for offset-binary, zero for two's complement.
    function automatic logic [63:0] mute_code(input int w, input bit obin);
        return obin ? (64'd1 << (w - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/src_switch_fmt.sv
// Output format stage: passes or mutes the selected sample.
// SRC_SWITCH_OFFSET_BIN_EN selects offset-binary output with a midscale mute code.
module src_switch_fmt
    import src_switch_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] sample,
    input  logic             mute,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] mute_val
);

`ifdef SRC_SWITCH_OFFSET_BIN_EN
    localparam logic [WIDTH-1:0] MUTE_CODE = WIDTH'(mute_code(WIDTH, 1'b1));

    always_comb begin
        mute_val = MUTE_CODE;
        q = mute ? MUTE_CODE : {~sample[WIDTH-1], sample[WIDTH-2:0]};
    end
`else
    localparam logic [WIDTH-1:0] MUTE_CODE = WIDTH'(mute_code(WIDTH, 1'b0));

    always_comb begin
        mute_val = MUTE_CODE;
        q = mute ? MUTE_CODE : sample;
    end
`endif

endmodule

// File: rtl/src_switch.sv
// N-way registered sample selector that inserts MUTE_LEN muted samples on a source change.
// Optional offset-binary output via SRC_SWITCH_OFFSET_BIN_EN (see src_switch_fmt).
module src_switch
    import src_switch_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int N_CH     = 2,
    parameter int SEL_W    = 1,
    parameter int MUTE_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic [SEL_W-1:0]      cur_sel
);

    localparam int CNT_W = clog2_min1(MUTE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((MUTE_LEN > 0) ? MUTE_LEN - 1 : 0);

    state_t           state, state_nx;
    logic [SEL_W-1:0] pending, pending_nx, cur_nx, idx;
    logic [CNT_W-1:0] count, count_nx;
    logic             mute, legal;
    logic [WIDTH-1:0] sample, fmt_q, mute_val;

    assign legal = int'(sel) < N_CH;
    assign sample = din[int'(idx)*WIDTH +: WIDTH];
    assign busy = (state == MUTE);

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        cur_nx     = cur_sel;
        count_nx   = count;
        mute       = 1'b0;
        idx        = cur_sel;
        if (sample_en) begin
            unique case (state)
                PASS: begin
                    if (sel != cur_sel && legal) begin
                        if (MUTE_LEN == 0) begin
                            cur_nx = sel;
                            idx    = sel;
                        end else begin
                            pending_nx = sel;
                            count_nx   = CNT_LOAD;
                            mute       = 1'b1;
                            if (MUTE_LEN == 1) cur_nx = sel;
                            else state_nx = MUTE;
                        end
                    end
                end
                MUTE: begin
                    mute     = 1'b1;
                    count_nx = count - 1'b1;
                    // Last muted sample: hand over to the latched channel.
                    if (count == CNT_W'(1)) begin
                        cur_nx   = pending;
                        state_nx = PASS;
                    end
                end
                default: state_nx = PASS;
            endcase
        end
    end

    src_switch_fmt #(.WIDTH(WIDTH)) u_fmt (
        .sample   (sample),
        .mute     (mute),
        .q        (fmt_q),
        .mute_val (mute_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PASS;
            pending    <= '0;
            count      <= '0;
            cur_sel    <= '0;
            dout       <= mute_val;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            pending    <= pending_nx;
            count      <= count_nx;
            cur_sel    <= cur_nx;
            dout_valid <= sample_en;
            if (sample_en) dout <= fmt_q;
        end
    end

endmodule
